demux_router_1x4: RTL and testbench
===================================

Name: demux_router_1x4

Overview:
- Registered 1-to-4 stream demultiplexer; the receive-side counterpart of the team's 4:1 selection mux tree.
- Routes each accepted input word to one of four output channels chosen by a 2-bit select.
- Each channel has a one-entry output buffer with valid/ready handshake and an accepted-word counter.
- Sits between a single producer and four independent consumers.

Parameters:
- WIDTH, 8, data word width in bits.
- CNT_W, 8, width of each per-channel accepted-word counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_data  input  WIDTH  input word.
- in_sel  input  2  destination select; channel index = {in_sel[0], in_sel[1]}, matching the mux tree bit order (in_sel=2'b10 -> ch1, 2'b01 -> ch2).
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept the word for the currently selected channel.
- out_data  output  4*WIDTH  channel i data at [i*WIDTH +: WIDTH].
- out_valid  output  4  per-channel buffer holds a word.
- out_ready  input  4  per-channel consumer accepts.
- chan_cnt  output  4*CNT_W  channel i count at [i*CNT_W +: CNT_W].

Behaviour:
- Reset (rst_n=0 sampled at clk edge):
  - out_valid=0, out_data=0, chan_cnt=0.
  - in_ready=0 combinationally for as long as rst_n=0.
  - A reset mid-operation discards all buffered words; counts are zeroed.
- ch = {in_sel[0], in_sel[1]}.
- in_ready = rst_n & (~out_valid[ch] | out_ready[ch]). This path is combinational from in_sel/out_valid/out_ready; no path from in_valid.
- Push: in_valid & in_ready. On the next edge:
  - out_data[ch] <= in_data, out_valid[ch] <= 1, chan_cnt[ch] += 1.
- Latency: word visible on out_data/out_valid one cycle after acceptance.
- Pop for channel i: out_valid[i] & out_ready[i]. On the next edge, out_valid[i] <= 0 unless a push to i occurs in the same cycle.
- Simultaneous push and pop on the same channel:
  - New word replaces the old one; out_valid stays 1.
  - Full throughput of 1 word/cycle per channel when out_ready is held high.
- Push to channel j with a pop on channel i (i != j) in the same cycle: both take effect independently.
- Channel i full with out_ready[i]=0: in_ready=0 when selecting i; the producer must hold in_valid/in_data/in_sel stable. Other channels stay unaffected.
- in_sel change while in_valid=1 and in_ready=0 is a protocol violation by the producer. The block makes no guarantee beyond evaluating in_ready against the new select.
- out_data[i] holds its last value after a pop; it is only meaningful while out_valid[i]=1.
- Counter rules:
  - Counts accepted pushes only, not pops.
  - Wraps modulo 2^CNT_W (e.g. 255 -> 0 for CNT_W=8), with no saturation flag.
- in_valid=0: no state change except pops.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=4'b0000, all chan_cnt=0; release -> in_ready=1.
- Bit-order routing: push 0xA1 sel=00, 0xB2 sel=10, 0xC3 sel=01, 0xD4 sel=11 with out_ready=0 -> out_valid=4'b1111, ch0=0xA1, ch1=0xB2, ch2=0xC3, ch3=0xD4, each chan_cnt=1.
- Backpressure: ch1 full, out_ready[1]=0, push sel=10 -> in_ready=0, data held; raise out_ready[1] -> in_ready=1 in the same cycle, new word replaces the old with out_valid[1] continuously 1.
- Streaming: 10 consecutive pushes to ch3 (0x00..0x09) with out_ready[3]=1 -> one accept per cycle, consumer sees 0x00..0x09 in order at 1-cycle latency, chan_cnt[3]=10.
- Wrap and reset mid-stream: 256 pushes to ch0 -> chan_cnt[0]=0 (CNT_W=8); then assert rst_n=0 with ch2 holding a word -> next edge out_valid=0 and all counts=0.

Source files
------------

// File: rtl/demux_router_1x4_if.sv
// Producer and four-consumer stream bundle for the 1:4 demux router.
// Channel i occupies bits [i*WIDTH +: WIDTH] of out_data and [i*CNT_W +: CNT_W] of chan_cnt.
interface demux_router_1x4_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*CNT_W-1:0] chan_cnt;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, chan_cnt
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, chan_cnt
    );
endinterface

// File: rtl/demux_router_1x4.sv
// Registered 1:4 stream demultiplexer: one-entry buffer and wrapping accept
// counter per channel, select bit order matching the 4:1 mux tree.
module demux_router_chan #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic [CNT_W-1:0] cnt
);
    // A push in the same cycle as a pop overwrites the slot and keeps it valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
            cnt   <= '0;
        end else if (push) begin
            data  <= din;
            valid <= 1'b1;
            cnt   <= cnt + 1'b1;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end
endmodule

module demux_router_1x4 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    demux_router_1x4_if.slave  bus
);
    localparam int NUM_CH = 4;

    logic [1:0]                    ch;
    logic [NUM_CH-1:0]             push;
    logic [NUM_CH-1:0]             pop;
    logic [NUM_CH-1:0]             valid_q;
    logic [NUM_CH-1:0][WIDTH-1:0]  data_q;
    logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q;

    // in_sel bit 0 is the MSB of the channel index (mux tree ordering).
    assign ch = {bus.in_sel[0], bus.in_sel[1]};

    assign bus.in_ready  = rst_n & (~valid_q[ch] | bus.out_ready[ch]);
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.chan_cnt  = cnt_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign push[i] = bus.in_valid & bus.in_ready & (ch == 2'(i));
        assign pop[i]  = valid_q[i] & bus.out_ready[i];

        demux_router_chan #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (bus.in_data),
            .data  (data_q[i]),
            .valid (valid_q[i]),
            .cnt   (cnt_q[i])
        );
    end
endmodule

// File: tb/tb_demux_router_1x4.sv
// Bench for demux_router_1x4: directed scenarios plus randomized traffic,
// checked against a per-channel slot/count model updated every clock edge.
module tb_demux_router_1x4;
    localparam int W  = 8;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    demux_router_1x4_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    demux_router_1x4 #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: one slot per channel, counts kept as plain integers.
    bit [3:0]   m_valid;
    logic [7:0] m_data [4];
    int         m_cnt  [4];

    function automatic int sel_idx(input logic [1:0] s);
        return int'(s[0]) * 2 + int'(s[1]);
    endfunction

    function automatic bit exp_ready();
        int c;
        c = sel_idx(bus.in_sel);
        return rst_n && (!m_valid[c] || bus.out_ready[c]);
    endfunction

    function automatic logic [7:0] d_data(input int i);
        return bus.out_data[i*W +: W];
    endfunction

    function automatic logic [7:0] d_cnt(input int i);
        return bus.chan_cnt[i*CW +: CW];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_valid[i] <= 1'b0;
                m_data[i]  <= '0;
                m_cnt[i]   <= 0;
            end
        end else begin
            for (int i = 0; i < 4; i++)
                if (m_valid[i] && bus.out_ready[i]) m_valid[i] <= 1'b0;
            if (bus.in_valid && exp_ready()) begin
                m_valid[sel_idx(bus.in_sel)] <= 1'b1;
                m_data[sel_idx(bus.in_sel)]  <= bus.in_data;
                m_cnt[sel_idx(bus.in_sel)]   <= (m_cnt[sel_idx(bus.in_sel)] + 1) % 256;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d);
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_data  = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.out_ready = 4'h0;
        drive(1'b1, 2'($urandom_range(0, 3)), 8'($urandom));
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL reset_in_ready cyc %0d: got %b exp 0", k, bus.in_ready);
            end
            tick();
        end
        checks++;
        if (bus.out_valid !== 4'b0000) begin
            errors++; $display("FAIL reset_out_valid: got %b exp 0000", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== '0 || bus.chan_cnt !== '0) begin
            errors++; $display("FAIL reset_data_cnt: data %h cnt %h exp 0", bus.out_data, bus.chan_cnt);
        end
        rst_n = 1'b1;
        drive(1'b0, 2'b00, 8'h00);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b exp 1", bus.in_ready);
        end
    endtask

    task automatic test_routing();
        logic [1:0] sel_tab [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
        logic [7:0] dat_tab [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        logic [7:0] ch_exp  [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        bus.out_ready = 4'h0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, sel_tab[k], dat_tab[k]);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL route_ready push %0d: got %b exp 1", k, bus.in_ready);
            end
            tick();
        end
        drive(1'b0, 2'b00, 8'h00);
        checks++;
        if (bus.out_valid !== 4'b1111) begin
            errors++; $display("FAIL route_valid: got %b exp 1111", bus.out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (d_data(i) !== ch_exp[i] || d_cnt(i) !== 8'd1) begin
                errors++;
                $display("FAIL route_ch%0d: data %h cnt %0d exp data %h cnt 1", i, d_data(i), d_cnt(i), ch_exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 4'h0;
        drive(1'b1, 2'b10, 8'h5E);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_blocked_ready: got %b exp 0", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid[1] !== 1'b1 || d_data(1) !== 8'hB2 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: valid %b data %h ready %b exp 1 b2 0", bus.out_valid[1], d_data(1), bus.in_ready);
        end
        bus.out_ready = 4'b0010;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready: got %b exp 1", bus.in_ready);
        end
        tick();
        drive(1'b0, 2'b00, 8'h00);
        bus.out_ready = 4'h0;
        checks++;
        if (bus.out_valid[1] !== 1'b1 || d_data(1) !== 8'h5E || d_cnt(1) !== 8'd2) begin
            errors++;
            $display("FAIL bp_replace: valid %b data %h cnt %0d exp 1 5e 2", bus.out_valid[1], d_data(1), d_cnt(1));
        end
        bus.out_ready = 4'hF;
        tick();
        bus.out_ready = 4'h0;
        checks++;
        if (bus.out_valid !== 4'b0000) begin
            errors++; $display("FAIL bp_drain: got %b exp 0000", bus.out_valid);
        end
    endtask

    task automatic test_streaming();
        logic [7:0] seen [$];
        logic [7:0] c0;
        c0 = d_cnt(3);
        bus.out_ready = 4'b1000;
        for (int k = 0; k <= 10; k++) begin
            if (bus.out_valid[3] && bus.out_ready[3]) seen.push_back(d_data(3));
            if (k > 0) begin
                checks++;
                if (bus.out_valid[3] !== 1'b1 || d_data(3) !== 8'(k - 1)) begin
                    errors++;
                    $display("FAIL stream_latency step %0d: valid %b data %h exp 1 %h", k, bus.out_valid[3], d_data(3), 8'(k - 1));
                end
            end
            if (k < 10) begin
                drive(1'b1, 2'b11, 8'(k));
                #1;
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    errors++; $display("FAIL stream_ready step %0d: got %b exp 1", k, bus.in_ready);
                end
            end else begin
                drive(1'b0, 2'b00, 8'h00);
            end
            tick();
        end
        bus.out_ready = 4'h0;
        checks++;
        if (seen.size() != 10) begin
            errors++; $display("FAIL stream_count: got %0d words exp 10", seen.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                checks++;
                if (seen[k] !== 8'(k)) begin
                    errors++; $display("FAIL stream_order idx %0d: got %h exp %h", k, seen[k], 8'(k));
                end
            end
        end
        checks++;
        if (d_cnt(3) !== 8'(c0 + 8'd10) || bus.out_valid[3] !== 1'b0) begin
            errors++;
            $display("FAIL stream_cnt: cnt %0d valid %b exp %0d 0", d_cnt(3), bus.out_valid[3], 8'(c0 + 8'd10));
        end
    endtask

    task automatic test_random();
        bit hold = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (bus.out_valid[i] !== m_valid[i]) begin
                    errors++; $display("FAIL rand_valid cyc %0d ch %0d: got %b exp %b", cyc, i, bus.out_valid[i], m_valid[i]);
                end
                if (m_valid[i]) begin
                    checks++;
                    if (d_data(i) !== m_data[i]) begin
                        errors++; $display("FAIL rand_data cyc %0d ch %0d: got %h exp %h", cyc, i, d_data(i), m_data[i]);
                    end
                end
                checks++;
                if (int'(d_cnt(i)) != m_cnt[i]) begin
                    errors++; $display("FAIL rand_cnt cyc %0d ch %0d: got %0d exp %0d", cyc, i, d_cnt(i), m_cnt[i]);
                end
            end
            if (!hold) drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom));
            bus.out_ready = 4'($urandom);
            #1;
            checks++;
            if (bus.in_ready !== exp_ready()) begin
                errors++; $display("FAIL rand_in_ready cyc %0d: got %b exp %b", cyc, bus.in_ready, exp_ready());
            end
            hold = bus.in_valid && !exp_ready();
            tick();
        end
        drive(1'b0, 2'b00, 8'h00);
        bus.out_ready = 4'h0;
    endtask

    task automatic test_wrap_reset();
        rst_n = 1'b0;
        drive(1'b0, 2'b00, 8'h00);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 4'b0001;
        for (int k = 0; k < 256; k++) begin
            drive(1'b1, 2'b00, 8'(k));
            if (k == 255) begin
                checks++;
                if (d_cnt(0) !== 8'd255) begin
                    errors++; $display("FAIL wrap_pre cnt: got %0d exp 255", d_cnt(0));
                end
            end
            tick();
        end
        drive(1'b0, 2'b00, 8'h00);
        checks++;
        if (d_cnt(0) !== 8'd0 || bus.out_valid[0] !== 1'b1 || d_data(0) !== 8'hFF) begin
            errors++;
            $display("FAIL wrap_cnt: cnt %0d valid %b data %h exp 0 1 ff", d_cnt(0), bus.out_valid[0], d_data(0));
        end
        bus.out_ready = 4'h0;
        drive(1'b1, 2'b01, 8'h3C);
        tick();
        drive(1'b0, 2'b00, 8'h00);
        checks++;
        if (bus.out_valid[2] !== 1'b1 || d_data(2) !== 8'h3C) begin
            errors++; $display("FAIL midrst_load: valid %b data %h exp 1 3c", bus.out_valid[2], d_data(2));
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 4'b0000 || bus.chan_cnt !== '0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear: valid %b cnt %h ready %b exp 0000 0 0", bus.out_valid, bus.chan_cnt, bus.in_ready);
        end
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        tick();
        test_routing();
        test_backpressure();
        test_streaming();
        test_random();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
